// File: rtl/regfile_writeback.sv
// Register file writeback arbiter: merges load and ALU results
// into one write per cycle through a small in-order FIFO.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     ld_ready,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  output logic                     we3,
  output logic [AW-1:0]            a3,
  output logic [XLEN-1:0]          wd3,
  input  logic [AW-1:0]            q_addr,
  output logic                     q_hit,
  output logic [XLEN-1:0]          q_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   alu_slot;
  logic [PW-1:0]   idx;
  logic            ld_push;
  logic            alu_push;
  logic            pop;

  // Load keeps the last free slot; ALU only takes it if load is idle.
  assign ld_ready  = count <= CW'(DEPTH - 1);
  assign alu_ready = (count <= CW'(DEPTH - 2)) ||
                     ((count == CW'(DEPTH - 1)) && !ld_valid);

  // x0 writes complete the handshake but never occupy a slot.
  assign ld_push  = !rst && ld_valid && ld_ready &&
                    (ld_rd != '0);
  assign alu_push = !rst && alu_valid && alu_ready &&
                    (alu_rd != '0);
  assign pop      = count != '0;

  // Load is older when both arrive, so ALU lands behind it.
  assign alu_slot = ld_push ? wptr + PW'(1) : wptr;

  assign we3 = pop;
  assign a3  = rd_q[rptr];
  assign wd3 = data_q[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + PW'(pop);
      wptr  <= wptr + PW'(ld_push) + PW'(alu_push);
      count <= count + CW'(ld_push) + CW'(alu_push)
               - CW'(pop);
    end
  end

  // Entry storage; contents past count are never observed.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      rd_q[wptr]   <= ld_rd;
      data_q[wptr] <= ld_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  // Bypass: scan oldest to youngest so the youngest match wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if ((CW'(i) < count) && (q_addr != '0) &&
          (rd_q[idx] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue model plus directed
// literal checks and randomized traffic.
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ld_valid = 1'b0;
  logic [AW-1:0]   ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            ld_ready;
  logic            alu_valid = 1'b0;
  logic [AW-1:0]   alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            alu_ready;
  logic            we3;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd3;
  logic [AW-1:0]   q_addr = '0;
  logic            q_hit;
  logic [XLEN-1:0] q_data;
  logic [CW-1:0]   count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t mq[$];

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .we3(we3), .a3(a3), .wd3(wd3),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
    .count(count)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ldr();
    return mq.size() <= DEPTH - 1;
  endfunction

  function automatic bit m_alur();
    return (mq.size() <= DEPTH - 2) ||
           (mq.size() == DEPTH - 1 && !ld_valid);
  endfunction

  // Reference model: a plain queue updated at each rising edge.
  always @(posedge clk) begin
    bit lr, ar;
    ent_t e;
    lr = m_ldr();
    ar = m_alur();
    if (rst) begin
      mq.delete();
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (ld_valid && lr && ld_rd != 0) begin
        e.rd = ld_rd; e.data = ld_data;
        mq.push_back(e);
      end
      if (alu_valid && ar && alu_rd != 0) begin
        e.rd = alu_rd; e.data = alu_data;
        mq.push_back(e);
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit hit;
      logic [XLEN-1:0] hd;
      hit = 1'b0;
      hd = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && q_addr != 0 && mq[i].rd == q_addr) begin
          hit = 1'b1;
          hd = mq[i].data;
        end
      end
      chk("count", 32'(count), 32'(mq.size()));
      chk("we3", 32'(we3), 32'(mq.size() != 0));
      chk("ld_ready", 32'(ld_ready), 32'(m_ldr()));
      chk("alu_ready", 32'(alu_ready), 32'(m_alur()));
      chk("q_hit", 32'(q_hit), 32'(hit));
      if (mq.size() != 0) begin
        chk("a3", 32'(a3), 32'(mq[0].rd));
        chk("wd3", wd3, mq[0].data);
      end
      if (hit) chk("q_data", q_data, hd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic ld(input int rd, input int d);
    ld_valid = 1'b1; ld_rd = AW'(rd); ld_data = XLEN'(d);
  endtask

  task automatic alu(input int rd, input int d);
    alu_valid = 1'b1; alu_rd = AW'(rd); alu_data = XLEN'(d);
  endtask

  initial begin
    int nrd;
    // reset then idle
    rst = 1'b1;
    idle();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_we3", 32'(we3), 0);
    chk("rst_ldr", 32'(ld_ready), 1);
    chk("rst_alur", 32'(alu_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_we3", 32'(we3), 0);
    @(posedge clk); #1;

    // single ALU write
    alu(1, 42);
    tick();
    idle();
    q_addr = 5'd1;
    @(negedge clk);
    chk("alu1_we3", 32'(we3), 1);
    chk("alu1_a3", 32'(a3), 1);
    chk("alu1_wd3", wd3, 42);
    chk("alu1_hit", 32'(q_hit), 1);
    chk("alu1_qd", q_data, 42);
    @(posedge clk); #1;
    @(negedge clk);
    chk("alu1_we3_off", 32'(we3), 0);
    chk("alu1_count", 32'(count), 0);
    @(posedge clk); #1;

    // simultaneous push to the same rd
    ld(3, 7);
    alu(3, 9);
    tick();
    idle();
    q_addr = 5'd3;
    @(negedge clk);
    chk("sim_count", 32'(count), 2);
    chk("sim_a3_0", 32'(a3), 3);
    chk("sim_wd3_0", wd3, 7);
    chk("sim_qd", q_data, 9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sim_a3_1", 32'(a3), 3);
    chk("sim_wd3_1", wd3, 9);
    chk("sim_qd_1", q_data, 9);
    @(posedge clk); #1;
    tick();

    // fill and backpressure, rd cycles through 1..8
    nrd = 1;
    for (int i = 0; i < 12; i++) begin
      ld(nrd, $urandom);
      alu((nrd % 8) + 1, $urandom);
      q_addr = AW'($urandom_range(1, 8));
      if (i == 2) begin
        @(negedge clk);
        chk("fill_count3", 32'(count), 3);
        chk("fill_alur_low", 32'(alu_ready), 0);
        chk("fill_ldr_high", 32'(ld_ready), 1);
      end
      @(posedge clk);
      if (ld_valid && ld_ready) nrd = (nrd % 8) + 1;
      if (alu_valid && alu_ready) nrd = (nrd % 8) + 1;
      #1;
    end
    idle();
    repeat (5) tick();

    // x0 drop
    alu(0, 122);
    q_addr = '0;
    @(negedge clk);
    chk("x0_alur", 32'(alu_ready), 1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("x0_count", 32'(count), 0);
    chk("x0_we3", 32'(we3), 0);
    chk("x0_hit", 32'(q_hit), 0);
    @(posedge clk); #1;

    // reset mid-operation with three pending entries
    ld(5, 55); alu(6, 66);
    tick();
    ld(7, 77); alu(9, 99);
    tick();
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 3);
    @(posedge clk); #1;
    rst = 1'b1;
    ld(10, 1); alu(11, 2);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_we3", 32'(we3), 0);
    for (int a = 0; a < 32; a++) begin
      #1 q_addr = AW'(a);
      #1 chk("mid_rst_hit", 32'(q_hit), 0);
    end
    @(posedge clk); #1;
    repeat (4) tick();

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      ld_valid = $urandom_range(0, 1);
      ld_rd = AW'($urandom_range(0, 7));
      ld_data = $urandom;
      alu_valid = $urandom_range(0, 1);
      alu_rd = AW'($urandom_range(0, 7));
      alu_data = $urandom;
      q_addr = AW'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
